// File: rtl/counter_ccu_pkg.sv
// counter_ccu_pkg: shared types for the capture/compare counter.
//   ccu_edge_t  : 2-bit edge qualifier code (none / rise / fall / both)
//   ccu_state_t : counter FSM state (idle / run)
package counter_ccu_pkg;

  typedef logic [1:0] ccu_edge_t;

  localparam ccu_edge_t EDGE_NONE = 2'b00;
  localparam ccu_edge_t EDGE_RISE = 2'b01;
  localparam ccu_edge_t EDGE_FALL = 2'b10;
  localparam ccu_edge_t EDGE_BOTH = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ccu_state_t;

endpackage

// File: rtl/counter_ccu_evt.sv
// counter_ccu_evt: selects one bit of the source bus and qualifies it with an
// edge code against the previous-cycle copy of the bus.
//   src       : current source bus
//   src_q     : source bus registered one cycle earlier (shared at top level)
//   sel       : bit select
//   edge_code : EDGE_NONE never fires
//   evt       : combinational event, valid in the cycle the transition is seen
module counter_ccu_evt
  import counter_ccu_pkg::*;
#(
  parameter int SRC_NUM = 8,
  parameter int SEL_W   = $clog2(SRC_NUM)
) (
  input  logic [SRC_NUM-1:0] src,
  input  logic [SRC_NUM-1:0] src_q,
  input  logic [SEL_W-1:0]   sel,
  input  ccu_edge_t          edge_code,
  output logic               evt
);

  logic cur, prv;

  assign cur = src[sel];
  assign prv = src_q[sel];

  always_comb begin
    evt = 1'b0;
    case (edge_code)
      EDGE_RISE: evt = cur & ~prv;
      EDGE_FALL: evt = ~cur & prv;
      EDGE_BOTH: evt = cur ^ prv;
      default:   evt = 1'b0;
    endcase
  end

endmodule

// File: rtl/counter_ccu.sv
// counter_ccu: one CNT_W-bit up-counter with programmable period shared by
// CH_NUM capture/compare channels. Start/stop/clear and per-channel capture
// events are selected from i_src and edge-qualified.
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_src                     : synchronised source bus
//   i_enable                  : block enable (0 forces idle, count 0, outputs 0)
//   i_sel_*/i_edge_*          : start/stop/clear source select and edge code
//   i_period, i_oneshot       : terminal count, stop after first wrap
//   i_ch_*                    : per-channel mode/select/edge/compare/overrun/read
//   i_int_en, i_wrap_clr      : interrupt enables (MSB = wrap), wrap flag clear
//   o_cnt, o_running          : count and run state
//   o_ch_cap/status/ovf/out   : capture data, capture valid, overrun, PWM
//   o_wrap_flag, o_int        : sticky wrap, level interrupt
module counter_ccu
  import counter_ccu_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int CH_NUM  = 4,
  parameter int SRC_NUM = 8,
  parameter int SEL_W   = $clog2(SRC_NUM)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SRC_NUM-1:0]      i_src,
  input  logic                    i_enable,
  input  logic [SEL_W-1:0]        i_sel_start,
  input  logic [SEL_W-1:0]        i_sel_stop,
  input  logic [SEL_W-1:0]        i_sel_clear,
  input  ccu_edge_t               i_edge_start,
  input  ccu_edge_t               i_edge_stop,
  input  ccu_edge_t               i_edge_clear,
  input  logic [CNT_W-1:0]        i_period,
  input  logic                    i_oneshot,
  input  logic [CH_NUM-1:0]       i_ch_mode,
  input  logic [CH_NUM*SEL_W-1:0] i_ch_sel,
  input  logic [CH_NUM*2-1:0]     i_ch_edge,
  input  logic [CH_NUM*CNT_W-1:0] i_ch_cmp,
  input  logic [CH_NUM-1:0]       i_ch_ovf_keep,
  input  logic [CH_NUM-1:0]       i_ch_read,
  input  logic [CH_NUM:0]         i_int_en,
  input  logic                    i_wrap_clr,
  output logic [CNT_W-1:0]        o_cnt,
  output logic                    o_running,
  output logic [CH_NUM*CNT_W-1:0] o_ch_cap,
  output logic [CH_NUM-1:0]       o_ch_status,
  output logic [CH_NUM-1:0]       o_ch_ovf,
  output logic [CH_NUM-1:0]       o_ch_out,
  output logic                    o_wrap_flag,
  output logic                    o_int
);

  logic [SRC_NUM-1:0]           src_q;
  logic                         start_evt, stop_evt, clear_evt;
  logic [CH_NUM-1:0]            ch_evt;
  ccu_state_t                   state;
  logic [CNT_W-1:0]             cnt;
  logic                         run, at_period, wrap, wrap_flag;
  logic [CH_NUM-1:0][CNT_W-1:0] ch_cap;
  logic [CH_NUM-1:0]            ch_status, ch_ovf, ch_out;

  // single history copy of the source bus, shared by every event detector
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) src_q <= '0;
    else          src_q <= i_src;
  end

  counter_ccu_evt #(.SRC_NUM(SRC_NUM), .SEL_W(SEL_W)) u_start_evt (
    .src(i_src), .src_q(src_q), .sel(i_sel_start), .edge_code(i_edge_start), .evt(start_evt)
  );
  counter_ccu_evt #(.SRC_NUM(SRC_NUM), .SEL_W(SEL_W)) u_stop_evt (
    .src(i_src), .src_q(src_q), .sel(i_sel_stop), .edge_code(i_edge_stop), .evt(stop_evt)
  );
  counter_ccu_evt #(.SRC_NUM(SRC_NUM), .SEL_W(SEL_W)) u_clear_evt (
    .src(i_src), .src_q(src_q), .sel(i_sel_clear), .edge_code(i_edge_clear), .evt(clear_evt)
  );

  assign run       = (state == ST_RUN);
  assign at_period = (cnt == i_period);
  // a clear in the same cycle wins over the terminal-count wrap
  assign wrap      = i_enable && run && !clear_evt && at_period;

  // Clear only touches the count; stop/start still steer the state, so a
  // simultaneous start+stop+clear lands in IDLE with count 0. A count above
  // the period simply rolls over through 2^CNT_W before matching again.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (!i_enable) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      if (clear_evt)   cnt <= '0;
      else if (run)    cnt <= at_period ? '0 : cnt + CNT_W'(1);
      if (stop_evt || (wrap && i_oneshot)) state <= ST_IDLE;
      else if (start_evt)                  state <= ST_RUN;
    end
  end

  // set beats clear when both land in the same cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)        wrap_flag <= 1'b0;
    else if (wrap)       wrap_flag <= 1'b1;
    else if (i_wrap_clr) wrap_flag <= 1'b0;
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic [CNT_W-1:0] cap_q;
    logic             st_q, ovf_q, out_q, cap_evt, rd;

    counter_ccu_evt #(.SRC_NUM(SRC_NUM), .SEL_W(SEL_W)) u_ch_evt (
      .src(i_src), .src_q(src_q), .sel(i_ch_sel[g*SEL_W +: SEL_W]),
      .edge_code(i_ch_edge[g*2 +: 2]), .evt(ch_evt[g])
    );

    assign cap_evt = ch_evt[g] & i_enable & i_ch_mode[g];
    assign rd      = i_ch_read[g];

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        cap_q <= '0;
        st_q  <= 1'b0;
        ovf_q <= 1'b0;
      end else if (cap_evt) begin
        if (!st_q || rd) begin
          // fresh capture, or the read consumed the old one this cycle
          cap_q <= cnt;
          st_q  <= 1'b1;
          if (rd) ovf_q <= 1'b0;
        end else begin
          ovf_q <= 1'b1;
          if (!i_ch_ovf_keep[g]) cap_q <= cnt;
        end
      end else if (rd) begin
        st_q  <= 1'b0;
        ovf_q <= 1'b0;
      end
    end

    // PWM: registered, so it trails o_cnt by one cycle
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) out_q <= 1'b0;
      else          out_q <= i_enable && !i_ch_mode[g] && run &&
                             (cnt >= i_ch_cmp[g*CNT_W +: CNT_W]);
    end

    assign ch_cap[g]    = cap_q;
    assign ch_status[g] = st_q;
    assign ch_ovf[g]    = ovf_q;
    assign ch_out[g]    = out_q;
  end

  assign o_cnt       = cnt;
  assign o_running   = run;
  assign o_ch_cap    = ch_cap;
  assign o_ch_status = ch_status;
  assign o_ch_ovf    = ch_ovf;
  assign o_ch_out    = ch_out;
  assign o_wrap_flag = wrap_flag;
  assign o_int       = |({wrap_flag, ch_status} & i_int_en);

endmodule
